// File: rtl/zone_alarm_ctrl.sv
// Multi-zone sequential alarm controller: arm/disarm, entry delay on masked
// zones, time-limited siren with auto re-arm. All outputs are registered.
module zone_alarm_ctrl #(
  parameter int                 N_ZONES     = 4,
  parameter logic [N_ZONES-1:0] DELAY_MASK  = 4'b0001,
  parameter int                 ENTRY_DELAY = 8,
  parameter int                 SIREN_TIME  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               disarm,
  input  logic               panic,
  input  logic [N_ZONES-1:0] zone_trip,
  output logic               armed,
  output logic               pending,
  output logic               siren,
  output logic               arm_fault,
  output logic [N_ZONES-1:0] zone_latch,
  output logic [1:0]         state
);

  localparam int MAX_T = (ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME;
  localparam int CW    = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] ENTRY_LOAD = CW'(ENTRY_DELAY - 1);
  localparam logic [CW-1:0] SIREN_LOAD = CW'(SIREN_TIME - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    PENDING  = 2'b10,
    ALARM    = 2'b11
  } stateT;

  stateT               curState, nextState;
  logic [CW-1:0]       cnt, nextCnt;
  logic                nextFault;
  logic [N_ZONES-1:0]  nextLatch;
  logic                inst, dly;

  assign inst  = |(zone_trip & ~DELAY_MASK);
  assign dly   = |(zone_trip & DELAY_MASK);
  assign state = curState;

  always_comb begin
    nextState = curState;
    nextCnt   = cnt;
    nextFault = 1'b0;
    if (panic) begin
      nextState = ALARM;
      nextCnt   = SIREN_LOAD;
    end else if (disarm) begin
      nextState = DISARMED;
      nextCnt   = '0;
    end else begin
      case (curState)
        DISARMED: begin
          if (arm) begin
            if (zone_trip == '0) nextState = ARMED;
            else                 nextFault = 1'b1;
          end
        end
        ARMED: begin
          if (inst) begin
            nextState = ALARM;
            nextCnt   = SIREN_LOAD;
          end else if (dly) begin
            nextState = PENDING;
            nextCnt   = ENTRY_LOAD;
          end
        end
        PENDING: begin
          // an instant zone cuts the entry delay short; further delayed trips do not restart it
          if (inst || cnt == '0) begin
            nextState = ALARM;
            nextCnt   = SIREN_LOAD;
          end else begin
            nextCnt = cnt - CW'(1);
          end
        end
        ALARM: begin
          if (cnt == '0) begin
            nextState = ARMED;
            nextCnt   = '0;
          end else begin
            nextCnt = cnt - CW'(1);
          end
        end
        default: begin
          nextState = DISARMED;
          nextCnt   = '0;
        end
      endcase
    end
    nextLatch = (nextState == DISARMED) ? '0 : (zone_latch | zone_trip);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState   <= DISARMED;
      cnt        <= '0;
      arm_fault  <= 1'b0;
      zone_latch <= '0;
      armed      <= 1'b0;
      pending    <= 1'b0;
      siren      <= 1'b0;
    end else begin
      curState   <= nextState;
      cnt        <= nextCnt;
      arm_fault  <= nextFault;
      zone_latch <= nextLatch;
      armed      <= (nextState != DISARMED);
      pending    <= (nextState == PENDING);
      siren      <= (nextState == ALARM);
    end
  end

endmodule
